// File: rtl/uart_rx_if.sv
// Serial-receive bundle: the raw line in, received word plus status pulses out.
interface uart_rx_if #(
    parameter int DBIT = 8
);
    logic            rx;
    logic [DBIT-1:0] rx_dout;
    logic            rx_done_tick;
    logic            frame_err;
    logic            busy;

    modport master (
        output rx,
        input  rx_dout,
        input  rx_done_tick,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rx,
        output rx_dout,
        output rx_done_tick,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: start-bit glitch rejection, LSB-first data,
// stop-bit framing check with one-cycle done / frame-error pulses.
module uart_rx #(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int BAUD_DIV = 651
) (
    input  logic       clk,
    input  logic       reset_n,
    uart_rx_if.slave   bus
);
    localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int NW = ($clog2(DBIT) > 0) ? $clog2(DBIT) : 1;
    localparam int CW = ($clog2(BAUD_DIV) > 0) ? $clog2(BAUD_DIV) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [1:0]      sync_q, sync_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    state_t          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;
    logic            rx_s;
    logic            s_tick;

    assign rx_s   = sync_q[1];
    assign s_tick = (cnt_q == CW'(BAUD_DIV - 1));

    always_comb begin
        sync_d  = {sync_q[0], bus.rx};
        cnt_d   = s_tick ? '0 : cnt_q + CW'(1);
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    s_d     = '0;
                    state_d = START;
                end
            end
            START: begin
                // A start bit still low at mid-bit is real; otherwise it was a glitch.
                if (s_tick) begin
                    if (s_q == SW'(7)) begin
                        if (!rx_s) begin
                            s_d     = '0;
                            n_d     = '0;
                            state_d = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == SW'(15)) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == NW'(DBIT - 1)) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        state_d = IDLE;
                        if (rx_s) begin
                            dout_d = b_q;
                            done_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign bus.rx_dout      = dout_q;
    assign bus.rx_done_tick = done_q;
    assign bus.frame_err    = ferr_q;
    assign bus.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at BAUD_DIV=2 (one bit = 32 clk cycles).
module tb_uart_rx;
    localparam int BAUD_DIV = 2;
    localparam int BIT_CLKS = 16 * BAUD_DIV;
    localparam int FRAME_CLKS = 10 * BIT_CLKS;

    logic clk = 1'b0;
    logic reset_n;

    uart_rx_if #(.DBIT(8)) bus ();

    uart_rx #(
        .DBIT    (8),
        .SB_TICK (16),
        .BAUD_DIV(BAUD_DIV)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int done_cnt   = 0;
    int ferr_cnt   = 0;
    int both_cnt   = 0;
    int wide_cnt   = 0;
    int bad_change = 0;
    logic [7:0] prev_dout = 8'h00;
    logic [7:0] last_done_dout = 8'h00;
    logic done_prev = 1'b0;
    logic ferr_prev = 1'b0;

    // Pulse monitor: counts pulses and flags illegal output behaviour.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_dout = bus.rx_dout;
            done_prev = 1'b0;
            ferr_prev = 1'b0;
        end else begin
            if (bus.rx_done_tick) begin
                done_cnt++;
                last_done_dout = bus.rx_dout;
            end
            if (bus.frame_err) ferr_cnt++;
            if (bus.rx_done_tick && bus.frame_err) both_cnt++;
            if ((bus.rx_done_tick && done_prev) || (bus.frame_err && ferr_prev)) wide_cnt++;
            if ((bus.rx_dout !== prev_dout) && !bus.rx_done_tick) bad_change++;
            prev_dout = bus.rx_dout;
            done_prev = bus.rx_done_tick;
            ferr_prev = bus.frame_err;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        bus.rx = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_data(input logic [7:0] d);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
    endtask

    task automatic send_frame(input logic [7:0] d);
        send_data(d);
        drive_bit(1'b1);
    endtask

    task automatic send_bad_stop(input logic [7:0] d);
        int waited;
        send_data(d);
        bus.rx = 1'b0;
        waited = 0;
        while (!bus.frame_err && waited < 2 * BIT_CLKS) begin
            @(negedge clk);
            waited++;
        end
        check("bad_stop_ferr_seen", 32'(bus.frame_err), 32'd1);
        repeat (2) @(negedge clk);
        bus.rx = 1'b1;
    endtask

    initial begin
        int base_d;
        int base_f;
        int seen;
        int cyc;

        reset_n = 1'b0;
        bus.rx  = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_dout", 32'(bus.rx_dout), 32'h00);
        check("reset_done", 32'(bus.rx_done_tick), 32'd0);
        check("reset_ferr", 32'(bus.frame_err), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        reset_n = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);

        // Single good frame
        base_d = done_cnt; base_f = ferr_cnt;
        send_frame(8'h55);
        check("f55_busy_after", 32'(bus.busy), 32'd0);
        check("f55_done_cnt", done_cnt - base_d, 32'd1);
        check("f55_ferr_cnt", ferr_cnt - base_f, 32'd0);
        check("f55_dout", 32'(bus.rx_dout), 32'h55);
        check("f55_pulse_dout", 32'(last_done_dout), 32'h55);

        // Back-to-back frames, no idle gap
        base_d = done_cnt;
        send_frame(8'hA3);
        check("fA3_dout", 32'(bus.rx_dout), 32'hA3);
        send_frame(8'h0F);
        check("f0F_dout", 32'(bus.rx_dout), 32'h0F);
        check("b2b_done_cnt", done_cnt - base_d, 32'd2);
        repeat (BIT_CLKS) @(negedge clk);

        // Three-tick glitch on idle line
        base_d = done_cnt; base_f = ferr_cnt;
        bus.rx = 1'b0;
        repeat (3 * BAUD_DIV) @(negedge clk);
        check("glitch_busy_high", 32'(bus.busy), 32'd1);
        bus.rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("glitch_busy_low", 32'(bus.busy), 32'd0);
        check("glitch_done_cnt", done_cnt - base_d, 32'd0);
        check("glitch_ferr_cnt", ferr_cnt - base_f, 32'd0);
        check("glitch_dout", 32'(bus.rx_dout), 32'h0F);

        // Stop bit forced low
        base_d = done_cnt; base_f = ferr_cnt;
        send_bad_stop(8'h81);
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("f81_ferr_cnt", ferr_cnt - base_f, 32'd1);
        check("f81_done_cnt", done_cnt - base_d, 32'd0);
        check("f81_dout_kept", 32'(bus.rx_dout), 32'h0F);
        check("f81_busy", 32'(bus.busy), 32'd0);

        // Reset during data bit 4
        base_d = done_cnt; base_f = ferr_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        bus.rx = 1'b0;
        repeat (BIT_CLKS / 2) @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_dout", 32'(bus.rx_dout), 32'h00);
        bus.rx  = 1'b1;
        reset_n = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("midrst_no_done", done_cnt - base_d, 32'd0);
        check("midrst_no_ferr", ferr_cnt - base_f, 32'd0);
        send_frame(8'h3C);
        repeat (BIT_CLKS) @(negedge clk);
        check("f3C_dout", 32'(bus.rx_dout), 32'h3C);
        check("f3C_done_cnt", done_cnt - base_d, 32'd1);

        // Break: line held low across several frame times
        base_d = done_cnt; base_f = ferr_cnt;
        bus.rx = 1'b0;
        seen = 0;
        cyc  = 0;
        while (seen < 3 && cyc < 4 * FRAME_CLKS) begin
            @(negedge clk);
            cyc++;
            if (bus.frame_err) seen++;
        end
        check("break_ferr_seen", seen, 32'd3);
        repeat (4) @(negedge clk);
        bus.rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("break_no_done", done_cnt - base_d, 32'd0);
        check("break_ferr_cnt", ferr_cnt - base_f, 32'd3);
        check("break_busy", 32'(bus.busy), 32'd0);
        send_frame(8'h7E);
        repeat (BIT_CLKS) @(negedge clk);
        check("f7E_dout", 32'(bus.rx_dout), 32'h7E);
        check("f7E_done_cnt", done_cnt - base_d, 32'd1);

        check("never_both_pulses", both_cnt, 32'd0);
        check("pulses_one_cycle", wide_cnt, 32'd0);
        check("dout_only_with_done", bad_change, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter DBIT, default 8, giving the number of data bits per frame (LSB first).
REQ-002 The block SHALL have parameter SB_TICK, default 16, giving the number of oversample ticks in the stop bit.
REQ-003 The block SHALL have parameter BAUD_DIV, default 651, giving the number of clk cycles per oversample tick (16 ticks per bit).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port rx, input, 1 bit: the serial line, asynchronous to clk, idle high.
REQ-007 The block SHALL have port rx_dout, output, DBIT bits: the last correctly framed data word.
REQ-008 The block SHALL have port rx_done_tick, output, 1 bit: a one-cycle pulse when rx_dout is updated.
REQ-009 The block SHALL have port frame_err, output, 1 bit: a one-cycle pulse when the stop bit samples low.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in idle.

Function
REQ-011 The block SHALL pass rx through a two-flop synchronizer (reset value 1); all FSM decisions SHALL use the synchronized value rx_s.
REQ-012 The block SHALL contain an internal free-running tick counter 0..BAUD_DIV-1 that asserts s_tick for one clk when the count equals BAUD_DIV-1 and then wraps to 0.
REQ-013 The FSM SHALL have four states: idle, start, data and stop; counters SHALL be s_reg (4 bits, ticks) and n_reg (clog2(DBIT) bits, data bits), with shift register b_reg (DBIT bits).
REQ-014 In idle, when rx_s is 0, the FSM SHALL clear s_reg and enter start on the next clk, independent of s_tick.
REQ-015 In start, on each s_tick the FSM SHALL check s_reg == 7 (mid-bit): if rx_s is 0 it SHALL clear s_reg and n_reg and enter data; if rx_s is 1 it SHALL return to idle (glitch rejection, no output pulse); otherwise it SHALL increment s_reg.
REQ-016 In data, on each s_tick with s_reg == 15 the FSM SHALL clear s_reg and shift b_reg right, loading rx_s into the MSB; otherwise it SHALL increment s_reg.
REQ-017 In data, after the shift for n_reg == DBIT-1 the FSM SHALL enter stop; otherwise n_reg SHALL increment.
REQ-018 In stop, on each s_tick with s_reg == SB_TICK-1 the FSM SHALL return to idle; otherwise it SHALL increment s_reg.
REQ-019 On the stop exit with rx_s == 1, the block SHALL load rx_dout from b_reg and pulse rx_done_tick high for exactly one clk.
REQ-020 On the stop exit with rx_s == 0, the block SHALL pulse frame_err for exactly one clk, leave rx_dout unchanged, and keep rx_done_tick low.
REQ-021 rx_done_tick and frame_err SHALL never be high in the same cycle; both SHALL be registered outputs.
REQ-022 rx_dout SHALL hold its value between frames and SHALL change only with rx_done_tick.
REQ-023 A line held low through the stop bit SHALL, after frame_err, be treated from idle as a new start bit (break condition: repeated frame_err, no hang).
REQ-024 s_reg and n_reg wrap-around SHALL be impossible: each is compared and cleared before it overflows for all legal parameter values (DBIT 5..9, SB_TICK 16/24/32 with s_reg widened to clog2(SB_TICK)).

Reset
REQ-025 On reset_n low, the block SHALL asynchronously set the state to idle, s_reg, n_reg, b_reg, rx_dout and the tick counter to 0, and rx_done_tick, frame_err and busy to 0, with synchronizer flops at 1.
REQ-026 A reset asserted mid-frame SHALL abandon the frame with no rx_done_tick or frame_err; after release the block SHALL wait in idle for the next falling edge.

Verification
REQ-027 With BAUD_DIV=2, send frame 0x55 with a good stop bit -> one rx_done_tick, rx_dout=0x55, frame_err stays 0, busy low again after the stop bit.
REQ-028 Send 0xA3 then, back-to-back with no idle gap, 0x0F -> two rx_done_tick pulses; rx_dout reads 0xA3, then 0x0F.
REQ-029 Drive a 3-tick low glitch on an idle line -> FSM returns to idle from start; no rx_done_tick, no frame_err, rx_dout unchanged.
REQ-030 Send 0x81 with the stop bit forced low -> frame_err pulses one clk, rx_done_tick 0, rx_dout keeps its previous value.
REQ-031 Assert reset_n low during data bit 4 of a frame, then release and send 0x3C -> no pulse from the aborted frame; rx_dout=0x3C after the new frame.
REQ-032 Hold rx low for 3 frame times -> repeated frame_err pulses, no rx_done_tick; after rx returns high, 0x7E is received correctly.
